// File: rtl/sum_block_averager_pkg.sv
// Shared types and constants for the sum block averager: FSM state encoding,
// accumulator width helper and the legal block-length exponent range.
package sum_block_averager_pkg;

    typedef logic [0:0] state_t;

    localparam state_t ST_IDLE  = 1'b0;
    localparam state_t ST_ACCUM = 1'b1;

    localparam int LOG2_SAMPLES_MIN = 1;
    localparam int LOG2_SAMPLES_MAX = 8;

    // Zero-extended samples summed N = 2^log2_samples times need log2_samples extra bits.
    function automatic int acc_width(input int data_width, input int log2_samples);
        return data_width + log2_samples;
    endfunction

endpackage

// File: rtl/sum_block_averager_counter.sv
// Modulo-2^Width sample counter with synchronous clear and terminal-count flag.
module sum_block_averager_counter #(
    parameter int Width = 2
) (
    input  logic             Clk_i,
    input  logic             Reset_n_i,
    input  logic             Clear_i,
    input  logic             Inc_i,
    output logic [Width-1:0] Count_o,
    output logic             Terminal_o
);

    logic [Width-1:0] count_q;

    // Sample count register; wraps naturally to zero after the terminal count.
    always_ff @(posedge Clk_i or negedge Reset_n_i) begin
        if (!Reset_n_i) begin
            count_q <= {Width{1'b0}};
        end else if (Clear_i) begin
            count_q <= {Width{1'b0}};
        end else if (Inc_i) begin
            count_q <= count_q + Width'(1'b1);
        end else begin
            count_q <= count_q;
        end
    end

    assign Count_o    = count_q;
    assign Terminal_o = &count_q;

endmodule

// File: rtl/sum_block_averager.sv
// Block averager for the add cell sum output: averages 2^Log2Samples valid samples.
// Build option SUM_BLOCK_AVERAGER_ROUNDING_EN selects round-half-up instead of truncation.
module sum_block_averager
    import sum_block_averager_pkg::*;
#(
    parameter int DataWidth   = 16,
    parameter int Log2Samples = 2
) (
    input  logic                   Clk_i,
    input  logic                   Reset_n_i,
    input  logic                   Enable_i,
    input  logic [DataWidth-1:0]   Sample_i,
    input  logic                   SampleValid_i,
    output logic [DataWidth-1:0]   Average_o,
    output logic                   AverageValid_o,
    output logic [Log2Samples-1:0] Count_o
);

    localparam int AccWidth = acc_width(DataWidth, Log2Samples);

    generate
        if (Log2Samples < LOG2_SAMPLES_MIN || Log2Samples > LOG2_SAMPLES_MAX) begin : g_bad_log2samples
            $error("sum_block_averager: Log2Samples must be within 1..8");
        end
    endgenerate

    state_t                 state_q, state_d;
    logic [AccWidth-1:0]    acc_q, acc_d;
    logic [DataWidth-1:0]   avg_q, avg_d;
    logic                   avg_valid_q, avg_valid_d;
    logic                   cnt_clr_s, cnt_inc_s, cnt_tc_s;
    logic [AccWidth-1:0]    sum_s, rounded_s;

    assign sum_s = acc_q + AccWidth'(Sample_i);

`ifdef SUM_BLOCK_AVERAGER_ROUNDING_EN
    localparam logic [AccWidth-1:0] RoundBias = {{(AccWidth-1){1'b0}}, 1'b1} << (Log2Samples - 1);
    assign rounded_s = sum_s + RoundBias;
`else
    assign rounded_s = sum_s;
`endif

    sum_block_averager_counter #(
        .Width (Log2Samples)
    ) u_counter (
        .Clk_i      (Clk_i),
        .Reset_n_i  (Reset_n_i),
        .Clear_i    (cnt_clr_s),
        .Inc_i      (cnt_inc_s),
        .Count_o    (Count_o),
        .Terminal_o (cnt_tc_s)
    );

    // Next-state logic; a dropped enable wins over any coincident sample.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        avg_d       = avg_q;
        avg_valid_d = 1'b0;
        cnt_clr_s   = 1'b0;
        cnt_inc_s   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                acc_d     = {AccWidth{1'b0}};
                cnt_clr_s = 1'b1;
                if (Enable_i) begin
                    state_d = ST_ACCUM;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACCUM: begin
                if (!Enable_i) begin
                    state_d   = ST_IDLE;
                    acc_d     = {AccWidth{1'b0}};
                    cnt_clr_s = 1'b1;
                end else if (SampleValid_i) begin
                    cnt_inc_s = 1'b1;
                    if (cnt_tc_s) begin
                        avg_d       = DataWidth'(rounded_s >> Log2Samples);
                        avg_valid_d = 1'b1;
                        acc_d       = {AccWidth{1'b0}};
                    end else begin
                        acc_d = sum_s;
                    end
                end else begin
                    acc_d = acc_q;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                acc_d     = {AccWidth{1'b0}};
                cnt_clr_s = 1'b1;
            end
        endcase
    end

    // State, accumulator and output registers.
    always_ff @(posedge Clk_i or negedge Reset_n_i) begin
        if (!Reset_n_i) begin
            state_q     <= ST_IDLE;
            acc_q       <= {AccWidth{1'b0}};
            avg_q       <= {DataWidth{1'b0}};
            avg_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            avg_q       <= avg_d;
            avg_valid_q <= avg_valid_d;
        end
    end

    assign Average_o      = avg_q;
    assign AverageValid_o = avg_valid_q;

endmodule

// File: tb/tb_sum_block_averager.sv
// Directed table-driven bench for sum_block_averager (DataWidth=16, Log2Samples=2).
module tb_sum_block_averager;

`ifdef SUM_BLOCK_AVERAGER_ROUNDING_EN
    localparam logic [15:0] EXP_122 = 16'd2;
    localparam logic [15:0] EXP_1TO4 = 16'd3;
    localparam logic [15:0] EXP_5TO8 = 16'd7;
`else
    localparam logic [15:0] EXP_122 = 16'd1;
    localparam logic [15:0] EXP_1TO4 = 16'd2;
    localparam logic [15:0] EXP_5TO8 = 16'd6;
`endif

    typedef struct {
        logic        en;
        logic        vld;
        logic [15:0] smp;
        logic        exp_v;
        logic [15:0] exp_avg;
        logic [1:0]  exp_cnt;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic [15:0] smp;
    logic        vld;
    logic [15:0] avg;
    logic        avg_v;
    logic [1:0]  cnt;

    int checks   = 0;
    int failures = 0;
    vec_t vecs[$];

    sum_block_averager #(
        .DataWidth   (16),
        .Log2Samples (2)
    ) dut (
        .Clk_i          (clk),
        .Reset_n_i      (rst_n),
        .Enable_i       (en),
        .Sample_i       (smp),
        .SampleValid_i  (vld),
        .Average_o      (avg),
        .AverageValid_o (avg_v),
        .Count_o        (cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic check_out(input string nm, input logic ev, input logic [15:0] ea, input logic [1:0] ec);
        check({nm, " valid"}, {31'd0, avg_v}, {31'd0, ev});
        check({nm, " avg"}, {16'd0, avg}, {16'd0, ea});
        check({nm, " cnt"}, {30'd0, cnt}, {30'd0, ec});
    endtask

    task automatic step(input logic e, input logic v, input logic [15:0] s);
        en  = e;
        vld = v;
        smp = s;
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic e, input logic v, input logic [15:0] s,
                       input logic ev, input logic [15:0] ea, input logic [1:0] ec);
        vec_t r;
        r.en = e; r.vld = v; r.smp = s; r.exp_v = ev; r.exp_avg = ea; r.exp_cnt = ec;
        vecs.push_back(r);
    endtask

    initial begin
        logic [15:0] held;
        int gap;

        rst_n = 1'b0;
        en    = 1'b0;
        vld   = 1'b0;
        smp   = 16'd0;
        #8;
        check_out("reset", 1'b0, 16'd0, 2'd0);
        rst_n = 1'b1;

        // Enable edge: coincident sample ignored, then 10,20,30,40 -> 25.
        add(1'b1, 1'b1, 16'd99, 1'b0, 16'd0, 2'd0);
        add(1'b1, 1'b1, 16'd10, 1'b0, 16'd0, 2'd1);
        add(1'b1, 1'b1, 16'd20, 1'b0, 16'd0, 2'd2);
        add(1'b1, 1'b1, 16'd30, 1'b0, 16'd0, 2'd3);
        add(1'b1, 1'b1, 16'd40, 1'b1, 16'd25, 2'd0);
        add(1'b1, 1'b0, 16'd0, 1'b0, 16'd25, 2'd0);
        // 1,2,2,2: truncation vs rounding.
        add(1'b1, 1'b1, 16'd1, 1'b0, 16'd25, 2'd1);
        add(1'b1, 1'b1, 16'd2, 1'b0, 16'd25, 2'd2);
        add(1'b1, 1'b1, 16'd2, 1'b0, 16'd25, 2'd3);
        add(1'b1, 1'b1, 16'd2, 1'b1, EXP_122, 2'd0);
        // Partial block 100,200 discarded by disable; then 4,4,4,4.
        add(1'b1, 1'b1, 16'd100, 1'b0, EXP_122, 2'd1);
        add(1'b1, 1'b1, 16'd200, 1'b0, EXP_122, 2'd2);
        add(1'b0, 1'b1, 16'd7, 1'b0, EXP_122, 2'd0);
        add(1'b1, 1'b1, 16'd50, 1'b0, EXP_122, 2'd0);
        add(1'b1, 1'b1, 16'd4, 1'b0, EXP_122, 2'd1);
        add(1'b1, 1'b1, 16'd4, 1'b0, EXP_122, 2'd2);
        add(1'b1, 1'b1, 16'd4, 1'b0, EXP_122, 2'd3);
        add(1'b1, 1'b1, 16'd4, 1'b1, 16'd4, 2'd0);
        // Back-to-back 1..8: two blocks, no lost sample.
        add(1'b1, 1'b1, 16'd1, 1'b0, 16'd4, 2'd1);
        add(1'b1, 1'b1, 16'd2, 1'b0, 16'd4, 2'd2);
        add(1'b1, 1'b1, 16'd3, 1'b0, 16'd4, 2'd3);
        add(1'b1, 1'b1, 16'd4, 1'b1, EXP_1TO4, 2'd0);
        add(1'b1, 1'b1, 16'd5, 1'b0, EXP_1TO4, 2'd1);
        add(1'b1, 1'b1, 16'd6, 1'b0, EXP_1TO4, 2'd2);
        add(1'b1, 1'b1, 16'd7, 1'b0, EXP_1TO4, 2'd3);
        add(1'b1, 1'b1, 16'd8, 1'b1, EXP_5TO8, 2'd0);
        // Disable on the Nth sample wins: no pulse.
        add(1'b1, 1'b1, 16'd9, 1'b0, EXP_5TO8, 2'd1);
        add(1'b1, 1'b1, 16'd9, 1'b0, EXP_5TO8, 2'd2);
        add(1'b1, 1'b1, 16'd9, 1'b0, EXP_5TO8, 2'd3);
        add(1'b0, 1'b1, 16'd9, 1'b0, EXP_5TO8, 2'd0);
        add(1'b1, 1'b0, 16'd0, 1'b0, EXP_5TO8, 2'd0);

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].en, vecs[i].vld, vecs[i].smp);
            check_out($sformatf("row%0d", i), vecs[i].exp_v, vecs[i].exp_avg, vecs[i].exp_cnt);
        end

        // Four 0xFFFF samples with random gaps: no overflow, pulse only after the 4th.
        held = EXP_5TO8;
        for (int k = 0; k < 4; k++) begin
            gap = $urandom_range(0, 5);
            for (int g = 0; g < gap; g++) begin
                step(1'b1, 1'b0, 16'hFFFF);
                check_out($sformatf("gap%0d_%0d", k, g), 1'b0, held, 2'(k));
            end
            step(1'b1, 1'b1, 16'hFFFF);
            if (k == 3) begin
                check_out("ffff_done", 1'b1, 16'hFFFF, 2'd0);
            end else begin
                check_out($sformatf("ffff%0d", k), 1'b0, held, 2'(k + 1));
            end
        end
        step(1'b1, 1'b0, 16'd0);
        check_out("ffff_after", 1'b0, 16'hFFFF, 2'd0);

        // Asynchronous mid-cycle reset after 3 samples.
        step(1'b1, 1'b1, 16'd3);
        step(1'b1, 1'b1, 16'd3);
        step(1'b1, 1'b1, 16'd3);
        check_out("pre_reset", 1'b0, 16'hFFFF, 2'd3);
        #2;
        rst_n = 1'b0;
        #1;
        check_out("async_reset", 1'b0, 16'd0, 2'd0);
        #9;
        rst_n = 1'b1;
        step(1'b1, 1'b1, 16'd77);
        check_out("post_reset_enable", 1'b0, 16'd0, 2'd0);
        step(1'b1, 1'b1, 16'd8);
        step(1'b1, 1'b1, 16'd8);
        step(1'b1, 1'b1, 16'd8);
        check_out("post_reset_3", 1'b0, 16'd0, 2'd3);
        step(1'b1, 1'b1, 16'd12);
        check_out("post_reset_avg", 1'b1, 16'd9, 2'd0);
        step(1'b1, 1'b0, 16'd0);
        check_out("post_reset_hold", 1'b0, 16'd9, 2'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sum_block_averager.md
Name: sum_block_averager

Overview:
- Downstream consumer of the 16-bit add cell's sum output D_o in the reconfigurable WSN sensor datapath.
- Collects 2^Log2Samples valid sums and emits their unsigned block average with a one-cycle valid pulse.
- Sits between the add cell and the threshold/compare and interrupt logic of the sensor FSM.

Parameters:
- DataWidth, 16, width of incoming sum samples and outgoing average.
- Log2Samples, 2, log2 of block length N; legal range 1..8; 0 is illegal and must fail elaboration.

Ports:
- Clk_i  in  1  system clock; all state updates on the rising edge.
- Reset_n_i  in  1  reset, asynchronous assert, active-low.
- Enable_i  in  1  1 = averaging active; 0 = return to Idle and discard the partial block.
- Sample_i  in  DataWidth  unsigned sum from the upstream add cell.
- SampleValid_i  in  1  Sample_i is valid this cycle.
- Average_o  out  DataWidth  last completed block average; held until the next block completes.
- AverageValid_o  out  1  one-cycle pulse; Average_o was updated this cycle.
- Count_o  out  Log2Samples  samples accepted in the current block (0..N-1).

Behaviour:
- Reset (async, Reset_n_i=0): state=Idle, accumulator=0, Count_o=0, Average_o=0, AverageValid_o=0.
- Accumulator width is DataWidth+Log2Samples. Samples are zero-extended, so the accumulator cannot overflow.
- Idle state:
  - Accumulator and count are held at 0, and SampleValid_i is ignored.
  - Enable_i=1 -> Accum on the next edge. A sample valid on that same edge is not taken.
- Accum state, SampleValid_i=1 and Count_o<N-1: acc <= acc+Sample_i; Count_o <= Count_o+1.
- Accum state, SampleValid_i=1 and Count_o==N-1 (block complete):
  - Average_o <= (acc+Sample_i) >> Log2Samples, truncating.
  - AverageValid_o <= 1 for exactly one cycle.
  - acc <= 0 and Count_o <= 0. State stays Accum, so the next block starts immediately with no dead cycle.
- Latency: Average_o and AverageValid_o change at the edge that takes the Nth sample, i.e. visible one cycle after the Nth valid is presented.
- SampleValid_i=0 in Accum: hold all state. Gaps of any length are allowed.
- Enable_i=0 in any state -> Idle next edge:
  - acc and count clear; Average_o keeps its last value; no pulse.
  - Enable_i=0 takes priority over a coincident SampleValid_i, including on the Nth sample.
- Back-to-back valids every cycle must be accepted without loss.
- Reset mid-block: all state cleared as above; no pulse is produced for the partial block.
- AverageValid_o is otherwise 0.

Optional Feature:
- Macro: SUM_BLOCK_AVERAGER_ROUNDING_EN
- Defined: Average_o = (sum + 2^(Log2Samples-1)) >> Log2Samples (round half up). This cannot overflow, because the maximum sum plus N/2 is less than N*2^DataWidth.
- Undefined: plain truncation, with no rounding adder synthesized.

Decomposition:
- Shared package holds:
  - state typedef (Idle, Accum);
  - function computing the accumulator width from DataWidth and Log2Samples;
  - the constant for the legal Log2Samples range.
- One natural sub-module: sum_block_averager_counter, a modulo-N sample counter with a terminal-count flag. The FSM and accumulator stay in the top module.

Test Plan (Log2Samples=2 unless stated):
- Enable=1; samples 10,20,30,40 on consecutive cycles -> Average_o=25 and AverageValid_o high for one cycle, one cycle after sample 40; Count_o back to 0.
- Samples 1,2,2,2 -> truncation gives Average_o=1; with SUM_BLOCK_AVERAGER_ROUNDING_EN, Average_o=2.
- Four samples of 0xFFFF with random gaps of 0-5 cycles -> Average_o=0xFFFF in both builds, no overflow; pulse only after the 4th valid.
- Samples 100,200, then Enable=0 for one cycle, then Enable=1 and samples 4,4,4,4 -> no pulse for the partial block; next Average_o=4; old Average_o held meanwhile.
- 8 back-to-back valids 1..8 -> two pulses: averages 2 (10/4) then 6 (26/4), with no sample lost between blocks.
- Reset_n_i low for one cycle after 3 samples (asynchronously, mid-cycle) -> all outputs 0 immediately; the next 4 samples produce their own average only.
